// File: rtl/booth_seq_multiplier_pkg.sv
// Shared widths and FSM encoding for the sequential Booth multiplier.
// N is fixed at 8 because the downstream ripple-carry adder is 8 bits wide.
package booth_seq_multiplier_pkg;
   localparam int N     = 8;
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;
endpackage

// File: rtl/ripple_carry_adder.sv
// 8-bit ripple-carry adder built from a chain of full-adder cells.
module ripple_carry_adder (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] s,
   output logic       cout
);
   logic [8:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < 8; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[8];
endmodule

// File: rtl/booth_seq_multiplier.sv
// Radix-2 Booth multiplier, signed 8x8 -> 16, one Booth step per clock.
// Valid/ready on both sides; one product in flight at a time.
module booth_seq_multiplier
   import booth_seq_multiplier_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     a,
   input  logic [N-1:0]     b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-1:0]   p,
   output logic             busy
);
   state_e             state_q, state_d;
   logic [N-1:0]       a_q, a_d;
   logic [N-1:0]       q_q, q_d;
   logic [N-1:0]       m_q, m_d;
   logic               q1_q, q1_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ov_q, ov_d;
   logic               rdy_en_q;

   logic [N-1:0]       bsel;
   logic               sub;
   logic [N-1:0]       sum;
   logic               cout;
   logic               sgn;

   always_comb begin
      bsel = '0;
      sub  = 1'b0;
      case ({q_q[0], q1_q})
         2'b01:   bsel = m_q;
         2'b10: begin
            bsel = ~m_q;
            sub  = 1'b1;
         end
         default: ;
      endcase
   end

   ripple_carry_adder u_rca (
      .a    (a_q),
      .b    (bsel),
      .cin  (sub),
      .s    (sum),
      .cout (cout)
   );

   // True 9th sum bit: keeps the shift correct when the 8-bit sum overflows (M=-128).
   assign sgn = a_q[N-1] ^ bsel[N-1] ^ cout;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      q_d     = q_q;
      m_d     = m_q;
      q1_d    = q1_q;
      cnt_d   = cnt_q;
      ov_d    = ov_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               m_d     = a;
               q_d     = b;
               a_d     = '0;
               q1_d    = 1'b0;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            a_d   = {sgn, sum[N-1:1]};
            q_d   = {sum[0], q_q[N-1:1]};
            q1_d  = q_q[0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N-1)) begin
               state_d = DONE;
               ov_d    = 1'b1;
            end
         end
         DONE: begin
            if (ov_q && out_ready) begin
               ov_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         q_q      <= '0;
         m_q      <= '0;
         q1_q     <= 1'b0;
         cnt_q    <= '0;
         ov_q     <= 1'b0;
         rdy_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         q_q      <= q_d;
         m_q      <= m_d;
         q1_q     <= q1_d;
         cnt_q    <= cnt_d;
         ov_q     <= ov_d;
         rdy_en_q <= 1'b1;
      end
   end

   // in_ready stays low until the first clock after reset release.
   assign in_ready  = (state_q == IDLE) && rdy_en_q;
   assign busy      = (state_q == CALC) || (state_q == DONE);
   assign out_valid = ov_q;
   assign p         = {a_q, q_q};
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed and randomized bench for booth_seq_multiplier.
module tb_booth_seq_multiplier;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a, b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] p;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   booth_seq_multiplier dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called just after a clock edge; returns just after the handshake edge.
   task automatic start(input logic [7:0] ta, input logic [7:0] tb_);
      int k = 0;
      while (!in_ready && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check("in_ready_before_load", {31'd0, in_ready}, 32'd1);
      a = ta; b = tb_; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 8'hA5; b = 8'h5A;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!out_valid && lat < 20);
   endtask

   task automatic run(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                      input logic [15:0] exp);
      int lat;
      start(ta, tb_);
      wait_done(lat);
      check({tag, "_latency"}, lat, 32'd8);
      check({tag, "_p"}, {16'd0, p}, {16'd0, exp});
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_ov_clear"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      int lat, hs, prev_hs;
      logic [7:0]  ra, rb;
      logic signed [15:0] e;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      #2;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_p", {16'd0, p}, 32'd0);
      #10 rst_n = 1'b1;
      #1 check("rel_in_ready_low", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      check("rel_in_ready_high", {31'd0, in_ready}, 32'd1);

      // Abort mid-calculation
      start(8'd3, 8'd5);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_p", {16'd0, p}, 32'd0);
      check("abort_in_ready", {31'd0, in_ready}, 32'd0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      check("abort_rel_in_ready", {31'd0, in_ready}, 32'd1);

      run("m3x5",       8'd3,    8'd5,    16'h000F);
      run("mm128xm128", 8'h80,   8'h80,   16'h4000);
      run("mm128x127",  8'h80,   8'h7F,   16'hC080);
      run("mm7x6",      8'hF9,   8'd6,    16'hFFD6);
      run("m0xm1",      8'd0,    8'hFF,   16'h0000);
      run("m127x127",   8'h7F,   8'h7F,   16'h3F01);
      run("mm1xm1",     8'hFF,   8'hFF,   16'h0001);
      run("m100xm3",    8'd100,  8'hFD,   16'hFED4);

      // Hold in DONE with back-pressure; input pulses must be ignored
      start(8'd12, 8'd11);
      wait_done(lat);
      check("hold_latency", lat, 32'd8);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; a = 8'd1; b = 8'd1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         check("hold_p", {16'd0, p}, 32'h0084);
         check("hold_out_valid", {31'd0, out_valid}, 32'd1);
         check("hold_in_ready", {31'd0, in_ready}, 32'd0);
         check("hold_busy", {31'd0, busy}, 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("hold_release_ov", {31'd0, out_valid}, 32'd0);
      check("hold_release_in_ready", {31'd0, in_ready}, 32'd1);
      run("m2x2", 8'd2, 8'd2, 16'h0004);

      // Back-to-back random stream
      in_valid = 1'b1; out_ready = 1'b1;
      prev_hs = 0;
      for (int i = 0; i < 1000; i++) begin
         int k = 0;
         while (!in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
         end
         check("rand_in_ready", {31'd0, in_ready}, 32'd1);
         ra = 8'($urandom); rb = 8'($urandom);
         a = ra; b = rb;
         e = $signed(ra) * $signed(rb);
         @(posedge clk); #1;
         hs = cyc;
         a = 8'($urandom); b = 8'($urandom);
         if (i > 0) check("rand_period", hs - prev_hs, 32'd10);
         prev_hs = hs;
         wait_done(lat);
         check("rand_latency", lat, 32'd8);
         check("rand_p", {16'd0, p}, {16'd0, e});
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
